// File: rtl/ram_mp.sv
// ram_mp: one byte-enabled write port, NUM_R registered read ports, selectable
// read-during-write policy, and a clear sequencer that zeroes the array after
// reset or on CLEAR.
// Optional feature: define RAM_MP_PARITY_EN to add per-byte even parity and
// the PARITY_ERR output.
module ram_mp #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_R      = 2,
  parameter int unsigned RDW_MODE   = 0
) (
  input  logic                          CLK,
  input  logic                          RESET_N,
  input  logic                          CLEAR,
  output logic                          BUSY,
  input  logic [ADDR_WIDTH-1:0]         ADRR_W,
  input  logic                          ENABLE_W,
  input  logic [DATA_WIDTH/8-1:0]       BE_W,
  input  logic [DATA_WIDTH-1:0]         Q_W,
  input  logic [NUM_R*ADDR_WIDTH-1:0]   ADRR_R,
  output logic [NUM_R*DATA_WIDTH-1:0]   Q_R
`ifdef RAM_MP_PARITY_EN
  ,
  output logic [NUM_R-1:0]              PARITY_ERR
`endif
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned NB    = DATA_WIDTH / 8;

  typedef enum logic {ST_SWEEP, ST_IDLE} state_t;

  state_t                  state_q, state_nxt;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_nxt;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   merged_w;
  logic [DATA_WIDTH-1:0]   rd_w [NUM_R];
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // Merge enabled write lanes over the currently stored word at ADRR_W.
  always_comb begin
    merged_w = mem[ADRR_W];
    for (int i = 0; i < NB; i++) begin
      if (BE_W[i]) merged_w[8*i +: 8] = Q_W[8*i +: 8];
    end
  end

  // Next-state logic: sweep counter, clear requests and array write control.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    mem_we    = 1'b0;
    mem_addr  = ADRR_W;
    mem_wdata = merged_w;
    case (state_q)
      ST_SWEEP: begin
        mem_we    = 1'b1;
        mem_addr  = cnt_q;
        mem_wdata = '0;
        if (CLEAR) begin
          cnt_nxt = '0;
        end else if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + ADDR_WIDTH'(1);
        end
      end
      ST_IDLE: begin
        mem_we = ENABLE_W && (BE_W != '0);
        if (CLEAR) begin
          state_nxt = ST_SWEEP;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_SWEEP;
        cnt_nxt   = '0;
      end
    endcase
  end

  // FSM state, sweep counter and BUSY registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_SWEEP;
      cnt_q   <= '0;
      BUSY    <= 1'b1;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      BUSY    <= (state_nxt == ST_SWEEP);
    end
  end

  // Data array; not reset, zeroed by the sweep instead.
  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  // Per-port read word, with optional forwarding of the merged write word.
  always_comb begin
    logic [ADDR_WIDTH-1:0] ra;
    ra = '0;
    for (int k = 0; k < NUM_R; k++) begin
      ra       = ADRR_R[k*ADDR_WIDTH +: ADDR_WIDTH];
      rd_w[k]  = mem[ra];
      if ((RDW_MODE == 1) && (state_q == ST_IDLE) && ENABLE_W && (ra == ADRR_W))
        rd_w[k] = merged_w;
    end
  end

  // Registered read data; forced to zero while sweeping.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      Q_R <= '0;
    end else begin
      for (int k = 0; k < NUM_R; k++) begin
        Q_R[k*DATA_WIDTH +: DATA_WIDTH] <= (state_q == ST_SWEEP) ? '0 : rd_w[k];
      end
    end
  end

`ifdef RAM_MP_PARITY_EN
  logic [NB-1:0]    par_mem [DEPTH];
  logic [NB-1:0]    merged_p;
  logic [NB-1:0]    par_wdata;
  logic [NB-1:0]    rd_p [NUM_R];
  logic [NUM_R-1:0] perr_c;

  // Parity of the merged write word: new lanes recomputed, others kept.
  always_comb begin
    merged_p = par_mem[ADRR_W];
    for (int i = 0; i < NB; i++) begin
      if (BE_W[i]) merged_p[i] = ^Q_W[8*i +: 8];
    end
    par_wdata = (state_q == ST_SWEEP) ? '0 : merged_p;
  end

  // Parity array, written alongside the data array.
  always_ff @(posedge CLK) begin
    if (mem_we) par_mem[mem_addr] <= par_wdata;
  end

  // Per-port parity check over every byte lane of the word being read.
  always_comb begin
    logic [ADDR_WIDTH-1:0] pa;
    pa     = '0;
    perr_c = '0;
    for (int k = 0; k < NUM_R; k++) begin
      pa      = ADRR_R[k*ADDR_WIDTH +: ADDR_WIDTH];
      rd_p[k] = par_mem[pa];
      if ((RDW_MODE == 1) && (state_q == ST_IDLE) && ENABLE_W && (pa == ADRR_W))
        rd_p[k] = merged_p;
      for (int i = 0; i < NB; i++) begin
        if ((^rd_w[k][8*i +: 8]) != rd_p[k][i]) perr_c[k] = 1'b1;
      end
    end
  end

  // Registered parity error flags, aligned with Q_R.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) PARITY_ERR <= '0;
    else          PARITY_ERR <= (state_q == ST_SWEEP) ? '0 : perr_c;
  end
`endif

endmodule

// File: doc/ram_mp.md
Name: ram_mp

Overview:
- Parametrised successor to the team's single-read dual-port RAM.
- Provides one write port with byte enables, NUM_R independent registered read ports, and a selectable read-during-write policy.
- Includes a hardware clear sequencer that zeroes the array after reset or on request.
- Serves as instruction/data storage and register-file backing for the RISC-V core.

Parameters:
- ADDR_WIDTH, 10, address bits; DEPTH = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, word width; must be a multiple of 8; NB = DATA_WIDTH/8 byte lanes.
- NUM_R, 2, number of read ports (1..4).
- RDW_MODE, 0, read-during-write policy on the same address: 0 = old data, 1 = new data (forwarded).

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- CLEAR  in  1  synchronous request to re-run the zeroing sweep.
- BUSY  out  1  high while the clear sequencer runs.
- ADRR_W  in  ADDR_WIDTH  write address.
- ENABLE_W  in  1  write enable.
- BE_W  in  NB  byte-lane enables; bit i selects Q_W[8i+7:8i].
- Q_W  in  DATA_WIDTH  write data.
- ADRR_R  in  NUM_R*ADDR_WIDTH  read addresses, flattened; port k uses slice k.
- Q_R  out  NUM_R*DATA_WIDTH  registered read data, flattened; port k uses slice k.

Behaviour:
- Reset (RESET_N low, asynchronous):
  - Q_R = 0, BUSY = 1, sweep counter = 0, FSM = SWEEP.
  - The array contents are not reset directly; they are zeroed by the sweep.
- FSM states:
  - SWEEP: each cycle write 0 to address cnt, then cnt++. When cnt = DEPTH-1 is written, go to IDLE on the next edge. BUSY = 1 for exactly DEPTH cycles after reset release.
  - IDLE: BUSY = 0; normal operation. CLEAR = 1 sampled at an edge sets cnt = 0 and returns to SWEEP with BUSY = 1 from the next cycle.
  - CLEAR while already in SWEEP restarts cnt at 0.
- During SWEEP:
  - ENABLE_W is ignored; the write is dropped, not queued.
  - Every Q_R slice registers 0.
- Write (IDLE, ENABLE_W = 1):
  - At the edge, lanes with BE_W[i] = 1 take Q_W bytes; other lanes keep their old bytes.
  - BE_W = 0 with ENABLE_W = 1 is a no-op.
- Read latency is 1 cycle:
  - Q_R slice k equals mem[ADRR_R slice k] sampled at the edge.
  - Q_R holds its value between edges.
  - All ports may read any address, including the same one, simultaneously.
- Read-during-write (same address, same edge):
  - RDW_MODE = 0: Q_R returns the pre-write word.
  - RDW_MODE = 1: Q_R returns the merged word: enabled lanes from Q_W, others from the old word.
  - Applies to each port independently.
- Reset mid-sweep or mid-write:
  - The in-flight write is lost; the FSM restarts the sweep from 0.
  - Array contents beyond what the restarted sweep has covered are undefined until the sweep finishes.
- Address arithmetic is unsigned; no out-of-range case exists because the array has full 2**ADDR_WIDTH depth.

Optional Feature:
- Macro: RAM_MP_PARITY_EN.
- Defined:
  - Adds one even-parity bit per byte lane, stored alongside the data.
  - Adds output PARITY_ERR [NUM_R-1:0], registered with the same 1-cycle latency as Q_R.
  - Bit k is set when any byte read on port k fails its parity check.
  - The sweep writes data 0 with parity 0.
  - PARITY_ERR resets to 0 and is forced to 0 during SWEEP.
- Undefined: the port and parity storage do not exist; behaviour is otherwise identical.

Test Plan:
- Bench uses ADDR_WIDTH = 4, DATA_WIDTH = 32, NUM_R = 2.
- Sweep: release RESET_N -> BUSY high for exactly 16 cycles, then low; reads of addresses 0..15 return 0x00000000.
- Byte enables: write 0xAABBCCDD to address 3 with BE_W = 4'b1111, then 0x11223344 to address 3 with BE_W = 4'b0101 -> port 0 reads 0xAA22CC44 one cycle after ADRR_R = 3.
- Dual read: address 1 = 0x12345678, address 2 = 0x9ABCDEF0; port 0 reads address 1 while port 1 reads address 2 -> both values appear on the same cycle; then both ports read address 2 -> 0x9ABCDEF0 on both.
- Read-during-write: address 5 = 0x0; write 0xFFFFFFFF to address 5 while both ports read address 5 -> RDW_MODE = 0 returns 0x0; RDW_MODE = 1 returns 0xFFFFFFFF.
- CLEAR and reset: pulse CLEAR in IDLE after writing address 7 -> BUSY rises next cycle, a write issued during the sweep is dropped, address 7 reads 0 afterwards. Assert RESET_N low at sweep cycle 5 -> BUSY stays high, and a full 16-cycle sweep follows release.
- Parity (macro defined): normal writes and reads -> PARITY_ERR = 0. Force-flip one stored data bit at address 9 -> PARITY_ERR[k] = 1 one cycle after port k reads address 9.
